// File: rtl/io_timer.sv
// Memory-mapped 16-bit timer with a power-of-two prescaler, a compare match flag
// and a level interrupt. The IO window is eight byte registers starting at BASE_ADDR.
module io_timer #(
    parameter logic [15:0] BASE_ADDR = 16'h1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] address,
    input  logic [7:0]  din,
    output logic [7:0]  dout,
    input  logic        write_en,
    input  logic        read_en,
    output logic        interrupt,
    input  logic        interrupt_clr
);

    localparam logic [2:0] OFF_CTRL   = 3'd0;
    localparam logic [2:0] OFF_CMP_L  = 3'd1;
    localparam logic [2:0] OFF_CMP_H  = 3'd2;
    localparam logic [2:0] OFF_CNT_L  = 3'd3;
    localparam logic [2:0] OFF_CNT_H  = 3'd4;
    localparam logic [2:0] OFF_STATUS = 3'd5;

    logic [5:0]  ctrl_q,  ctrl_d;
    logic [15:0] cmp_q,   cmp_d;
    logic [15:0] cnt_q,   cnt_d;
    logic [7:0]  snap_q,  snap_d;
    logic [6:0]  presc_q, presc_d;
    logic        match_q, match_d;
    logic [7:0]  dout_q,  dout_d;

    logic       hit, wr_hit, rd_hit;
    logic [2:0] off;
    logic       wr_ctrl, wr_cnt_l, wr_status;
    logic       en;
    logic [6:0] presc_mask;
    logic       tick, is_match;
    logic [7:0] rdata;

    assign hit       = (address[15:3] == BASE_ADDR[15:3]);
    assign off       = address[2:0];
    assign wr_hit    = write_en & hit;
    assign rd_hit    = read_en & hit;
    assign wr_ctrl   = wr_hit && (off == OFF_CTRL);
    assign wr_cnt_l  = wr_hit && (off == OFF_CNT_L);
    assign wr_status = wr_hit && (off == OFF_STATUS);

    assign en = ctrl_q[0];
    // Low PS bits of the prescaler all set marks the last clock of a 2^PS period.
    assign presc_mask = ~(7'h7F << ctrl_q[4:2]);
    // A counter clear outranks a tick landing in the same cycle.
    assign tick      = en && ((presc_q & presc_mask) == presc_mask) && !wr_cnt_l;
    assign is_match  = tick && (cnt_q == cmp_q);

    assign interrupt = match_q & ctrl_q[1];
    assign dout      = dout_q;

    always_comb begin
        rdata = 8'h00;
        case (off)
            OFF_CTRL:   rdata = {2'b00, ctrl_q};
            OFF_CMP_L:  rdata = cmp_q[7:0];
            OFF_CMP_H:  rdata = cmp_q[15:8];
            OFF_CNT_L:  rdata = cnt_q[7:0];
            OFF_CNT_H:  rdata = snap_q;
            OFF_STATUS: rdata = {7'b0, match_q};
            default:    rdata = 8'h00;
        endcase
    end

    always_comb begin
        ctrl_d  = ctrl_q;
        cmp_d   = cmp_q;
        cnt_d   = cnt_q;
        snap_d  = snap_q;
        presc_d = presc_q;
        match_d = match_q;
        dout_d  = 8'h00;

        if (wr_ctrl) begin
            ctrl_d = din[5:0];
        end else if (is_match && ctrl_q[5]) begin
            ctrl_d[0] = 1'b0;
        end

        if (wr_hit && off == OFF_CMP_L) cmp_d[7:0]  = din;
        if (wr_hit && off == OFF_CMP_H) cmp_d[15:8] = din;

        if (wr_ctrl || wr_cnt_l) begin
            presc_d = 7'd0;
        end else if (en) begin
            presc_d = presc_q + 7'd1;
        end

        if (wr_cnt_l) begin
            cnt_d = 16'd0;
        end else if (tick) begin
            cnt_d = is_match ? 16'd0 : cnt_q + 16'd1;
        end

        // A fresh match wins over any same-cycle acknowledge.
        if (is_match) begin
            match_d = 1'b1;
        end else if (interrupt_clr || (wr_status && din[0])) begin
            match_d = 1'b0;
        end

        // Read data reflects register contents before any same-cycle write.
        if (rd_hit) begin
            dout_d = rdata;
            if (off == OFF_CNT_L) snap_d = cnt_q[15:8];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_q  <= 6'd0;
            cmp_q   <= 16'hFFFF;
            cnt_q   <= 16'd0;
            snap_q  <= 8'd0;
            presc_q <= 7'd0;
            match_q <= 1'b0;
            dout_q  <= 8'd0;
        end else begin
            ctrl_q  <= ctrl_d;
            cmp_q   <= cmp_d;
            cnt_q   <= cnt_d;
            snap_q  <= snap_d;
            presc_q <= presc_d;
            match_q <= match_d;
            dout_q  <= dout_d;
        end
    end

endmodule

// File: tb/tb_io_timer.sv
// Directed bench for io_timer: register access, tick/match timing, one-shot,
// snapshot coherence, acknowledge priority and reset override.
module tb_io_timer;

    localparam logic [15:0] BASE = 16'h1000;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] address = 16'h0000;
    logic [7:0]  din = 8'h00;
    logic [7:0]  dout;
    logic        write_en = 1'b0;
    logic        read_en = 1'b0;
    logic        interrupt;
    logic        interrupt_clr = 1'b0;

    int n_total = 0;
    int n_bad   = 0;
    logic [7:0] d;

    io_timer #(.BASE_ADDR(BASE)) dut (
        .clk           (clk),
        .reset         (reset),
        .address       (address),
        .din           (din),
        .dout          (dout),
        .write_en      (write_en),
        .read_en       (read_en),
        .interrupt     (interrupt),
        .interrupt_clr (interrupt_clr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        step;
        reset = 1'b0;
    endtask

    task automatic wr_addr(input logic [15:0] a, input logic [7:0] v);
        address  = a;
        din      = v;
        write_en = 1'b1;
        step;
        write_en = 1'b0;
    endtask

    task automatic rd_addr(input logic [15:0] a, output logic [7:0] v);
        address = a;
        read_en = 1'b1;
        step;
        read_en = 1'b0;
        v = dout;
    endtask

    task automatic wr(input logic [2:0] off, input logic [7:0] v);
        wr_addr(BASE | {13'd0, off}, v);
    endtask

    task automatic rd(input logic [2:0] off, output logic [7:0] v);
        rd_addr(BASE | {13'd0, off}, v);
    endtask

    initial begin
        // Reset values
        do_reset;
        check("rst_dout", {8'h0, dout}, 16'h00);
        check("rst_irq", {15'h0, interrupt}, 16'h0);
        rd(0, d); check("rst_ctrl", {8'h0, d}, 16'h00);
        rd(1, d); check("rst_cmp_l", {8'h0, d}, 16'hFF);
        rd(2, d); check("rst_cmp_h", {8'h0, d}, 16'hFF);
        rd(3, d); check("rst_cnt_l", {8'h0, d}, 16'h00);
        rd(4, d); check("rst_cnt_h", {8'h0, d}, 16'h00);
        rd(5, d); check("rst_status", {8'h0, d}, 16'h00);

        // CMP=3, PS=0: first match 4 ticks after enable, then every 4 clocks
        do_reset;
        wr(1, 8'h03); wr(2, 8'h00); wr(0, 8'h03);
        repeat (3) step;
        check("p0_irq_t3", {15'h0, interrupt}, 16'h0);
        step;
        check("p0_irq_t4", {15'h0, interrupt}, 16'h1);
        interrupt_clr = 1'b1; step; interrupt_clr = 1'b0;
        check("p0_clr_t5", {15'h0, interrupt}, 16'h0);
        step; step;
        check("p0_irq_t7", {15'h0, interrupt}, 16'h0);
        step;
        check("p0_irq_t8", {15'h0, interrupt}, 16'h1);
        interrupt_clr = 1'b1; step; interrupt_clr = 1'b0;
        check("p0_clr_t9", {15'h0, interrupt}, 16'h0);
        step; step;
        interrupt_clr = 1'b1; step; interrupt_clr = 1'b0;
        check("set_wins_clr_t12", {15'h0, interrupt}, 16'h1);
        wr(5, 8'h01);
        check("status_w1c_t13", {15'h0, interrupt}, 16'h0);
        step; step; step;
        check("p0_irq_t16", {15'h0, interrupt}, 16'h1);

        // Reset overrides same-cycle write, read and acknowledge
        reset = 1'b1; write_en = 1'b1; read_en = 1'b1; interrupt_clr = 1'b1;
        address = BASE; din = 8'h3F;
        step;
        reset = 1'b0; write_en = 1'b0; read_en = 1'b0; interrupt_clr = 1'b0;
        check("rst_mid_irq", {15'h0, interrupt}, 16'h0);
        check("rst_mid_dout", {8'h0, dout}, 16'h00);
        rd(0, d); check("rst_mid_ctrl", {8'h0, d}, 16'h00);
        rd(1, d); check("rst_mid_cmp_l", {8'h0, d}, 16'hFF);
        rd(3, d); check("rst_mid_cnt_l", {8'h0, d}, 16'h00);
        rd(5, d); check("rst_mid_status", {8'h0, d}, 16'h00);

        // CMP=0, PS=0: match every clock
        do_reset;
        wr(1, 8'h00); wr(2, 8'h00); wr(0, 8'h03);
        step;
        check("cmp0_irq", {15'h0, interrupt}, 16'h1);
        interrupt_clr = 1'b1; step; interrupt_clr = 1'b0;
        check("cmp0_set_wins", {15'h0, interrupt}, 16'h1);
        rd(3, d); check("cmp0_cnt", {8'h0, d}, 16'h00);

        // PS=2, CMP=1: tick every 4 clocks, interrupt 8 clocks after CTRL write
        do_reset;
        wr(1, 8'h01); wr(2, 8'h00); wr(0, 8'h0B);
        repeat (7) step;
        check("ps2_irq_t7", {15'h0, interrupt}, 16'h0);
        step;
        check("ps2_irq_t8", {15'h0, interrupt}, 16'h1);
        interrupt_clr = 1'b1; step; interrupt_clr = 1'b0;
        check("ps2_clr", {15'h0, interrupt}, 16'h0);

        // One-shot: EN drops on the match, counter parks at zero
        do_reset;
        wr(1, 8'h02); wr(2, 8'h00); wr(0, 8'h21);
        repeat (6) step;
        rd(0, d); check("os_ctrl", {8'h0, d}, 16'h20);
        rd(5, d); check("os_status", {8'h0, d}, 16'h01);
        rd(3, d); check("os_cnt", {8'h0, d}, 16'h00);
        check("os_irq_masked", {15'h0, interrupt}, 16'h0);
        repeat (10) step;
        rd(3, d); check("os_cnt_hold", {8'h0, d}, 16'h00);

        // Snapshot coherence across the 0x12FF -> 0x1300 rollover
        do_reset;
        wr(0, 8'h01);
        repeat (4863) step;
        rd(3, d); check("snap_cnt_l", {8'h0, d}, 16'hFF);
        rd(4, d); check("snap_cnt_h", {8'h0, d}, 16'h12);
        wr(3, 8'h55);
        rd(3, d); check("cntl_clear", {8'h0, d}, 16'h00);
        rd(3, d); check("cntl_restart", {8'h0, d}, 16'h01);

        // Decode, reserved offsets, read/write collision, idle bus
        do_reset;
        wr(0, 8'hFF);
        rd(0, d); check("ctrl_mask", {8'h0, d}, 16'h3F);
        wr_addr(16'h1008, 8'h00);
        rd(0, d); check("outside_wr", {8'h0, d}, 16'h3F);
        wr(6, 8'hAA);
        rd(6, d); check("reserved_rd", {8'h0, d}, 16'h00);
        rd_addr(16'h2000, d); check("outside_rd", {8'h0, d}, 16'h00);
        address = BASE | 16'h1; din = 8'h5A; write_en = 1'b1; read_en = 1'b1;
        step;
        write_en = 1'b0; read_en = 1'b0;
        check("rw_same_old", {8'h0, dout}, 16'hFF);
        rd(1, d); check("rw_same_new", {8'h0, d}, 16'h5A);
        step;
        check("dout_idle", {8'h0, dout}, 16'h00);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/io_timer.md
IO_TIMER -- requirements
Module: io_timer

Interface
REQ-001 Parameter BASE_ADDR, default 16'h1000, first of 8 consecutive IO addresses decoded by the block.
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 address  input  16  CPU data/IO address bus.
REQ-005 din  input  8  CPU write data.
REQ-006 dout  output  8  registered read data to CPU.
REQ-007 write_en  input  1  CPU write strobe, one cycle per write.
REQ-008 read_en  input  1  CPU read strobe, one cycle per read.
REQ-009 interrupt  output  1  level interrupt request to CPU.
REQ-010 interrupt_clr  input  1  one-cycle acknowledge from CPU when the interrupt is taken.

Function
REQ-011 Hit SHALL be address[15:3] == BASE_ADDR[15:3]; offset = address[2:0]; strobes without hit SHALL have no effect.
REQ-012 Register map SHALL be: 0 CTRL (rw), 1 CMP_L (rw), 2 CMP_H (rw), 3 CNT_L (r; write clears counter), 4 CNT_H (r, snapshot), 5 STATUS (r; write-1-to-clear), 6-7 reserved (read 0, writes ignored).
REQ-013 CTRL SHALL hold bit0 EN, bit1 IRQ_EN, bits[4:2] PS, bit5 ONESHOT; bits[7:6] SHALL read 0.
REQ-014 Prescaler: 7-bit free counter running while EN=1; tick SHALL occur every 2^PS clocks (PS=0: every clock while EN=1).
REQ-015 Prescaler SHALL reset to 0 on any CTRL write and on any CNT_L write.
REQ-016 Counter: 16-bit CNT; on tick, if CNT == {CMP_H,CMP_L} then CNT <= 0 and MATCH <= 1, else CNT <= CNT+1.
REQ-017 CMP = 0 with EN=1, PS=0 SHALL produce a match every clock.
REQ-018 ONESHOT=1: on match the block SHALL clear EN in the same cycle; CNT holds 0 afterwards.
REQ-019 CNT SHALL wrap 16'hFFFF -> 0 without setting MATCH when CMP is unreachable (never occurs, since CMP <= FFFF; listed for completeness).
REQ-020 CNT_L write SHALL set CNT to 0 regardless of din; takes priority over a same-cycle tick.
REQ-021 Read: dout SHALL be valid in the cycle after read_en with hit, and SHALL be 8'h00 in every other cycle (OR-able onto a shared bus).
REQ-022 Reading CNT_L SHALL return CNT[7:0] and latch CNT[15:8] into a snapshot; reading CNT_H SHALL return the snapshot.
REQ-023 STATUS bit0 = MATCH; bits[7:1] read 0; writing din[0]=1 SHALL clear MATCH.
REQ-024 interrupt SHALL equal MATCH & IRQ_EN (combinational from registers, no extra latency).
REQ-025 interrupt_clr=1 SHALL clear MATCH.
REQ-026 Same-cycle MATCH set (from tick) and clear (interrupt_clr or STATUS write) SHALL leave MATCH=1.
REQ-027 Simultaneous read_en and write_en to the same offset: write SHALL take effect; dout SHALL return the pre-write value.
REQ-028 Writes to CMP SHALL take effect next cycle; compare uses the updated value from then on.

Reset
REQ-029 On reset: CTRL=0, CMP=16'hFFFF, CNT=0, snapshot=0, prescaler=0, MATCH=0, dout=0, interrupt=0.
REQ-030 Reset mid-count SHALL abandon the count; no MATCH or interrupt in the cycle following reset.
REQ-031 reset SHALL override all same-cycle writes and interrupt_clr.

Verification
REQ-032 Write CMP=0x0003, CTRL=0x03 (EN, IRQ_EN, PS=0) -> MATCH/interrupt first rises 4 ticks after EN, then every 4 clocks until cleared.
REQ-033 CTRL=0x0B (PS=2), CMP=0x0001 -> tick every 4 clocks; interrupt rises 8 clocks after CTRL write; interrupt_clr drops it next cycle.
REQ-034 CTRL=0x21 (ONESHOT, EN), CMP=0x0002 -> one match; CTRL reads 0x20 afterwards; CNT stays 0.
REQ-035 Counter at 0x12FF, read CNT_L then CNT_H across rollover -> returns 0xFF then 0x12 (snapshot coherent).
REQ-036 Tick match and interrupt_clr in same cycle -> interrupt stays 1; read of reserved offset 6 -> dout 0x00; read with address outside block -> dout 0x00.
REQ-037 Assert reset while EN=1 and interrupt=1 -> next cycle all registers at reset values, interrupt=0, dout=0.
